// File: rtl/median_column_feeder_if.sv
// Pixel-in / column-out bundle for median_column_feeder.
//  master: pixel source side. It drives pix_valid_i, sof_i and pix_i, and it
//          observes the column outputs.
//  slave : the feeder itself. It receives the pixel stream and drives
//          en_o, d1_o/d2_o/d3_o, col_o, row_o, frame_done_o and short_frame_o.
interface median_column_feeder_if #(
  parameter int DATA_W = 8,
  parameter int IMG_W  = 640,
  parameter int IMG_H  = 480
);
  localparam int COL_W = $clog2(IMG_W);
  localparam int ROW_W = $clog2(IMG_H);

  logic              pix_valid_i;
  logic              sof_i;
  logic [DATA_W-1:0] pix_i;
  logic              en_o;
  logic [DATA_W-1:0] d1_o;
  logic [DATA_W-1:0] d2_o;
  logic [DATA_W-1:0] d3_o;
  logic [COL_W-1:0]  col_o;
  logic [ROW_W-1:0]  row_o;
  logic              frame_done_o;
  logic              short_frame_o;

  modport master (
    output pix_valid_i, sof_i, pix_i,
    input  en_o, d1_o, d2_o, d3_o, col_o, row_o, frame_done_o, short_frame_o
  );

  modport slave (
    input  pix_valid_i, sof_i, pix_i,
    output en_o, d1_o, d2_o, d3_o, col_o, row_o, frame_done_o, short_frame_o
  );
endinterface

// File: rtl/median_column_feeder.sv
// median_column_feeder: turns a raster pixel stream into vertically aligned
// 3-pixel columns (rows y-2, y-1, y) for a median filter.
// Two line buffers hold the previous two rows. When a pixel is accepted at
// (r, c), the block emits one column one cycle later. The column strobe is
// raised only once r >= 2.
// Ports:
//  clk, rst : clock; synchronous active-high reset
//  bus      : slave modport of median_column_feeder_if. Pixel stream in
//             (pix_valid_i, sof_i, pix_i). Column out (en_o, d1_o..d3_o,
//             col_o, row_o). Frame pulses out (frame_done_o, short_frame_o).
module median_column_feeder #(
  parameter int DATA_W = 8,
  parameter int IMG_W  = 640,
  parameter int IMG_H  = 480
) (
  input  logic                   clk,
  input  logic                   rst,
  median_column_feeder_if.slave  bus
);
  localparam int COL_W = $clog2(IMG_W);
  localparam int ROW_W = $clog2(IMG_H);

  // Line buffers are data only and are never cleared. Stale contents are
  // masked by the row >= 2 gate on the column strobe.
  logic [DATA_W-1:0] r_lb0 [IMG_W];  // row y-1
  logic [DATA_W-1:0] r_lb1 [IMG_W];  // row y-2

  logic [COL_W-1:0]  r_col;
  logic [ROW_W-1:0]  r_row;

  logic              w_acc;
  logic              w_sof_acc;
  logic [COL_W-1:0]  w_col_cur;
  logic [ROW_W-1:0]  w_row_cur;
  logic              w_last_col;
  logic              w_last_row;
  logic [COL_W-1:0]  w_col_nxt;
  logic [ROW_W-1:0]  w_row_nxt;

  logic              r_vld_p1;
  logic [DATA_W-1:0] r_d1_p1;
  logic [DATA_W-1:0] r_d2_p1;
  logic [DATA_W-1:0] r_d3_p1;
  logic [COL_W-1:0]  r_col_p1;
  logic [ROW_W-1:0]  r_row_p1;
  logic              r_frame_done_p1;
  logic              r_short_p1;

  // A start-of-frame pixel is forced to (0,0), whatever the counters held.
  always_comb begin
    w_acc      = bus.pix_valid_i;
    w_sof_acc  = bus.pix_valid_i & bus.sof_i;
    w_col_cur  = w_sof_acc ? '0 : r_col;
    w_row_cur  = w_sof_acc ? '0 : r_row;
    w_last_col = (w_col_cur == COL_W'(IMG_W - 1));
    w_last_row = (w_row_cur == ROW_W'(IMG_H - 1));
    w_col_nxt  = w_last_col ? '0 : w_col_cur + COL_W'(1);
    w_row_nxt  = w_row_cur;
    if (w_last_col) begin
      w_row_nxt = w_last_row ? '0 : w_row_cur + ROW_W'(1);
    end
  end

  // Stage p0 -> p1: counters and registered column outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_col           <= '0;
      r_row           <= '0;
      r_vld_p1        <= 1'b0;
      r_d1_p1         <= '0;
      r_d2_p1         <= '0;
      r_d3_p1         <= '0;
      r_col_p1        <= '0;
      r_row_p1        <= '0;
      r_frame_done_p1 <= 1'b0;
      r_short_p1      <= 1'b0;
    end else if (w_acc) begin
      r_col           <= w_col_nxt;
      r_row           <= w_row_nxt;
      r_vld_p1        <= (w_row_cur >= ROW_W'(2));
      r_d1_p1         <= r_lb1[w_col_cur];
      r_d2_p1         <= r_lb0[w_col_cur];
      r_d3_p1         <= bus.pix_i;
      r_col_p1        <= w_col_cur;
      r_row_p1        <= w_row_cur;
      r_frame_done_p1 <= w_last_col & w_last_row;
      r_short_p1      <= w_sof_acc & ((r_col != '0) | (r_row != '0));
    end else begin
      r_vld_p1        <= 1'b0;
      r_frame_done_p1 <= 1'b0;
      r_short_p1      <= 1'b0;
    end
  end

  // Line buffer shift. Non-blocking writes give read-before-write for the
  // same entry, so the p1 stage above sees the previous rows.
  always_ff @(posedge clk) begin
    if (w_acc && !rst) begin
      r_lb1[w_col_cur] <= r_lb0[w_col_cur];
      r_lb0[w_col_cur] <= bus.pix_i;
    end
  end

  assign bus.en_o          = r_vld_p1;
  assign bus.d1_o          = r_d1_p1;
  assign bus.d2_o          = r_d2_p1;
  assign bus.d3_o          = r_d3_p1;
  assign bus.col_o         = r_col_p1;
  assign bus.row_o         = r_row_p1;
  assign bus.frame_done_o  = r_frame_done_p1;
  assign bus.short_frame_o = r_short_p1;
endmodule
